// File: rtl/ntt_radix_2_ctrl.sv
// Sequencer for an in-place radix-2 NTT/INTT: walks all stages, issues butterfly
// read/twiddle addresses and replays them as write-back strobes after the butterfly latency.
module ntt_radix_2_ctrl #(
  parameter int N          = 256,
  parameter int LOGN       = 8,
  parameter int BF_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  output logic            done,
  output logic            select,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_1,
  output logic [LOGN-1:0] rd_addr_2,
  output logic [LOGN-1:0] tw_addr_1,
  output logic [LOGN-1:0] tw_addr_2,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_1,
  output logic [LOGN-1:0] wr_addr_2,
  output logic [LOGN-1:0] stage
);

  localparam int DW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [LOGN-2:0] p_q, p_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            sel_d;
  logic [LOGN-1:0] a1_d, a2_d, tw_d;

  logic [BF_LATENCY-1:0]           wen_pipe;
  logic [BF_LATENCY-1:0][LOGN-1:0] wa1_pipe;
  logic [BF_LATENCY-1:0][LOGN-1:0] wa2_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
      select  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
      select  <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    sel_d   = select;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          p_d     = '0;
          stage_d = '0;
          sel_d   = mode;
        end
      end
      RUN: begin
        if (p_q == '1) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(BF_LATENCY - 1)) begin
          if (stage_q == LOGN'(LOGN - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            p_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses are computed from the next-cycle pair/stage so they can be registered alongside rd_en.
  always_comb begin
    int s, pi, h, g, j, a1, tw;
    s  = int'(stage_d);
    pi = int'(p_d);
    if (!sel_d) begin
      h  = N >> (s + 1);
      g  = pi >> (LOGN - 1 - s);
      j  = pi & (h - 1);
      a1 = (g << (LOGN - s)) + j;
      tw = (1 << s) + g;
    end else begin
      h  = 1 << s;
      g  = pi >> s;
      j  = pi & (h - 1);
      a1 = (g << (s + 1)) + j;
      tw = (N >> (s + 1)) + g;
    end
    a1_d = LOGN'(a1);
    a2_d = LOGN'(a1 + h);
    tw_d = LOGN'(tw);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr_1 <= '0;
      rd_addr_2 <= '0;
      tw_addr_2 <= '0;
    end else begin
      rd_en     <= (state_d == RUN);
      rd_addr_1 <= (state_d == RUN) ? a1_d : '0;
      rd_addr_2 <= (state_d == RUN) ? a2_d : '0;
      tw_addr_2 <= (state_d == RUN) ? tw_d : '0;
    end
  end

  // Write-back replays the read stream BF_LATENCY cycles later; reset flushes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_pipe <= '0;
      wa1_pipe <= '0;
      wa2_pipe <= '0;
    end else begin
      wen_pipe[0] <= rd_en;
      wa1_pipe[0] <= rd_addr_1;
      wa2_pipe[0] <= rd_addr_2;
      for (int i = 1; i < BF_LATENCY; i++) begin
        wen_pipe[i] <= wen_pipe[i-1];
        wa1_pipe[i] <= wa1_pipe[i-1];
        wa2_pipe[i] <= wa2_pipe[i-1];
      end
    end
  end

  assign wr_en     = wen_pipe[BF_LATENCY-1];
  assign wr_addr_1 = wa1_pipe[BF_LATENCY-1];
  assign wr_addr_2 = wa2_pipe[BF_LATENCY-1];
  assign tw_addr_1 = '0;
  assign stage     = stage_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_ntt_radix_2_ctrl.sv
// Self-checking bench for ntt_radix_2_ctrl (N=8): table-driven butterfly orderings
// fed into a cycle-stamped scoreboard, plus reset, ignored-start, back-to-back and abort sequences.
module tb_ntt_radix_2_ctrl;

  localparam int N   = 8;
  localparam int LOGN = 3;
  localparam int BFL  = 2;
  localparam int NBF  = (N / 2) * LOGN;

  logic            clk = 1'b0;
  logic            rst_n, start, mode;
  logic            busy, done, select, rd_en, wr_en;
  logic [LOGN-1:0] rd_addr_1, rd_addr_2, tw_addr_1, tw_addr_2;
  logic [LOGN-1:0] wr_addr_1, wr_addr_2, stage;

  ntt_radix_2_ctrl #(.N(N), .LOGN(LOGN), .BF_LATENCY(BFL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .select(select),
    .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .tw_addr_1(tw_addr_1), .tw_addr_2(tw_addr_2),
    .wr_en(wr_en), .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2),
    .stage(stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic            md;
    logic [LOGN-1:0] a1, a2, tw;
  } bfly_vec_t;

  typedef struct {
    logic rst_n, start, mode;
    logic busy, done, rd_en, wr_en;
  } rst_vec_t;

  typedef struct {
    int              cyc;
    logic [LOGN-1:0] a1, a2, tw, stg;
    logic            sel;
  } exp_t;

  bfly_vec_t vecs [2*NBF];
  rst_vec_t  rvecs[4];
  exp_t      rd_q[$];
  exp_t      wr_q[$];
  int        done_q[$];

  int n_compared = 0;
  int n_mismatched = 0;
  int wr_count = 0;
  int t0 = 0;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (rd_en) begin
      if (rd_q.size() == 0) checkOutput("rd_extra", 32'(rd_en), 0);
      else begin
        e = rd_q.pop_front();
        checkOutput("rd_cycle", cyc, e.cyc);
        checkOutput("rd_addr_1", 32'(rd_addr_1), 32'(e.a1));
        checkOutput("rd_addr_2", 32'(rd_addr_2), 32'(e.a2));
        checkOutput("tw_addr_1", 32'(tw_addr_1), 0);
        checkOutput("tw_addr_2", 32'(tw_addr_2), 32'(e.tw));
        checkOutput("stage", 32'(stage), 32'(e.stg));
        checkOutput("select", 32'(select), 32'(e.sel));
      end
    end
    if (wr_en) begin
      wr_count++;
      if (wr_q.size() == 0) checkOutput("wr_extra", 32'(wr_en), 0);
      else begin
        e = wr_q.pop_front();
        checkOutput("wr_cycle", cyc, e.cyc);
        checkOutput("wr_addr_1", 32'(wr_addr_1), 32'(e.a1));
        checkOutput("wr_addr_2", 32'(wr_addr_2), 32'(e.a2));
      end
    end
    if (done) begin
      if (done_q.size() == 0) checkOutput("done_extra", 32'(done), 0);
      else checkOutput("done_cycle", cyc, done_q.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 0);
    checkOutput({tag, "_addrs"}, 32'({rd_addr_1, rd_addr_2, tw_addr_1, tw_addr_2, wr_addr_1, wr_addr_2}), 0);
    checkOutput({tag, "_stage"}, 32'(stage), 0);
    checkOutput({tag, "_select"}, 32'(select), 0);
  endtask

  // Drive a one-cycle start; when it should be accepted, load the scoreboard with the expected stream.
  task automatic applyStimulus(input logic m, input bit accept);
    exp_t e;
    int   s, k;
    start = 1'b1;
    mode  = m;
    if (accept) begin
      t0 = cyc + 1;
      wr_count = 0;
      for (int i = 0; i < NBF; i++) begin
        s = i / (N / 2);
        k = i % (N / 2);
        e.cyc = t0 + s * (N / 2 + BFL) + k;
        e.a1  = vecs[int'(m) * NBF + i].a1;
        e.a2  = vecs[int'(m) * NBF + i].a2;
        e.tw  = vecs[int'(m) * NBF + i].tw;
        e.stg = LOGN'(s);
        e.sel = m;
        rd_q.push_back(e);
        e.cyc = e.cyc + BFL;
        wr_q.push_back(e);
      end
      done_q.push_back(t0 + LOGN * (N / 2 + BFL));
    end
    tick();
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic waitDone();
    for (int k = 0; k < 80 && (rd_q.size() + wr_q.size() + done_q.size()) != 0; k++) tick();
    checkOutput("sb_drained", rd_q.size() + wr_q.size() + done_q.size(), 0);
    checkOutput("wr_count", wr_count, NBF);
    tick();
    checkOutput("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 3'd4, 3'd1}; vecs[1]  = '{1'b0, 3'd1, 3'd5, 3'd1};
    vecs[2]  = '{1'b0, 3'd2, 3'd6, 3'd1}; vecs[3]  = '{1'b0, 3'd3, 3'd7, 3'd1};
    vecs[4]  = '{1'b0, 3'd0, 3'd2, 3'd2}; vecs[5]  = '{1'b0, 3'd1, 3'd3, 3'd2};
    vecs[6]  = '{1'b0, 3'd4, 3'd6, 3'd3}; vecs[7]  = '{1'b0, 3'd5, 3'd7, 3'd3};
    vecs[8]  = '{1'b0, 3'd0, 3'd1, 3'd4}; vecs[9]  = '{1'b0, 3'd2, 3'd3, 3'd5};
    vecs[10] = '{1'b0, 3'd4, 3'd5, 3'd6}; vecs[11] = '{1'b0, 3'd6, 3'd7, 3'd7};
    vecs[12] = '{1'b1, 3'd0, 3'd1, 3'd4}; vecs[13] = '{1'b1, 3'd2, 3'd3, 3'd5};
    vecs[14] = '{1'b1, 3'd4, 3'd5, 3'd6}; vecs[15] = '{1'b1, 3'd6, 3'd7, 3'd7};
    vecs[16] = '{1'b1, 3'd0, 3'd2, 3'd2}; vecs[17] = '{1'b1, 3'd1, 3'd3, 3'd2};
    vecs[18] = '{1'b1, 3'd4, 3'd6, 3'd3}; vecs[19] = '{1'b1, 3'd5, 3'd7, 3'd3};
    vecs[20] = '{1'b1, 3'd0, 3'd4, 3'd1}; vecs[21] = '{1'b1, 3'd1, 3'd5, 3'd1};
    vecs[22] = '{1'b1, 3'd2, 3'd6, 3'd1}; vecs[23] = '{1'b1, 3'd3, 3'd7, 3'd1};

    rvecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rvecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rvecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rvecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      rst_n = rvecs[i].rst_n;
      start = rvecs[i].start;
      mode  = rvecs[i].mode;
      tick();
      checkOutput("rst_busy", 32'(busy), 32'(rvecs[i].busy));
      checkOutput("rst_done", 32'(done), 32'(rvecs[i].done));
      checkOutput("rst_rd_en", 32'(rd_en), 32'(rvecs[i].rd_en));
      checkOutput("rst_wr_en", 32'(wr_en), 32'(rvecs[i].wr_en));
      checkOutput("rst_addrs", 32'({rd_addr_1, rd_addr_2, tw_addr_1, tw_addr_2, wr_addr_1, wr_addr_2}), 0);
      checkOutput("rst_stage_sel", 32'({stage, select}), 0);
    end
    start = 1'b0;
    mode  = 1'b0;

    $display("[TB] NTT run with a stray INTT start mid-transform");
    applyStimulus(1'b0, 1'b1);
    repeat (4) tick();
    applyStimulus(1'b1, 1'b0);
    waitDone();

    $display("[TB] INTT run started on the cycle after done");
    applyStimulus(1'b1, 1'b1);
    waitDone();

    $display("[TB] abort during stage 1");
    applyStimulus(1'b0, 1'b1);
    while (cyc < t0 + 8) tick();
    rst_n = 1'b0;
    tick();
    checkIdle("abort");
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("abort_quiet_busy", 32'(busy), 0);

    $display("[TB] NTT run after abort");
    applyStimulus(1'b0, 1'b1);
    waitDone();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ntt_radix_2_ctrl.md
Name: ntt_radix_2_ctrl

Overview:
Sequencing controller that sits directly upstream of the radix-2 NTT/INTT butterfly core. It steps through all log2(N) stages of an in-place N-point transform. For every butterfly it issues the coefficient-memory read pair, the twiddle-ROM addresses and the NTT/INTT select. It also delays the addresses to produce aligned write-back strobes, and drains the pipeline between stages so that no read-after-write hazard reaches the butterfly.

Parameters:
N, 256, transform length; power of two, at least 4.
LOGN, 8, log2(N); also the address width.
BF_LATENCY, 2, cycles from rd_en/rd_addr to the matching butterfly result being valid for write-back (memory read plus butterfly); at least 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
start  input  1  one-cycle request to begin a transform; ignored unless idle.
mode  input  1  0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande); sampled with start.
busy  output  1  high while a transform is in progress.
done  output  1  one-cycle pulse when the transform completes.
select  output  1  latched mode; drives the butterfly select.
rd_en  output  1  read strobe for the coefficient memory.
rd_addr_1  output  LOGN  address feeding butterfly input_1.
rd_addr_2  output  LOGN  address feeding butterfly input_2.
tw_addr_1  output  LOGN  twiddle-ROM address for input_twiddle_1; constant 0 (ROM entry 0 = 1).
tw_addr_2  output  LOGN  twiddle-ROM address for input_twiddle_2.
wr_en  output  1  write strobe for the butterfly outputs.
wr_addr_1  output  LOGN  address for output_1.
wr_addr_2  output  LOGN  address for output_2.
stage  output  LOGN  current stage index, 0..LOGN-1.

Behaviour:
- Reset (rst_n=0 at a clock edge): the FSM enters IDLE, all counters clear, and every output is 0. The delay line is flushed, so no wr_en is issued after reset. Reset mid-transform aborts it and produces no done pulse.
- FSM states and transitions:
  - IDLE to RUN when start=1; mode is latched into select at the same time.
  - RUN lasts exactly N/2 cycles per stage. rd_en=1 every cycle, and the pair counter p runs 0..N/2-1.
  - After p=N/2-1, RUN moves to DRAIN. DRAIN lasts BF_LATENCY cycles with rd_en=0.
  - At the end of DRAIN: if stage<LOGN-1, increment stage and return to RUN with p=0; otherwise go to DONE.
  - DONE lasts one cycle with done=1, then returns to IDLE.
- busy=1 in RUN, DRAIN and DONE, and 0 in IDLE. start is ignored while busy=1.
- NTT address generation at stage s:
  - h = N>>(s+1), g = p>>(LOGN-1-s), j = p&(h-1).
  - rd_addr_1 = g*2h + j; rd_addr_2 = rd_addr_1 + h.
  - tw_addr_2 = (1<<s) + g.
- INTT address generation at stage s:
  - h = 1<<s, g = p>>s, j = p&(h-1).
  - rd_addr_1 = g*2h + j; rd_addr_2 = rd_addr_1 + h.
  - tw_addr_2 = (N>>(s+1)) + g, indexing the inverse-root ROM; ROM selection by select is external.
- All address outputs are registered and valid in the same cycle as rd_en.
- Write-back:
  - wr_en, wr_addr_1 and wr_addr_2 are rd_en, rd_addr_1 and rd_addr_2 delayed by exactly BF_LATENCY cycles through a shift register.
  - The last write of each stage lands in the final DRAIN cycle, so the next stage's first read never overlaps a pending write.
- Timing: transform latency from the start edge to the done pulse is LOGN*(N/2+BF_LATENCY)+1 cycles.
- Scaling by N^-1 after INTT is out of scope; tw_addr_1 stays 0 in both modes.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> busy, done, rd_en and wr_en stay 0 and all addresses read 0.
- NTT ordering (N=8, LOGN=3, BF_LATENCY=2, mode=0):
  - stage 0 pairs (0,4)(1,5)(2,6)(3,7), tw_addr_2=1,1,1,1;
  - stage 1 pairs (0,2)(1,3)(4,6)(5,7), tw_addr_2=2,2,3,3;
  - stage 2 pairs (0,1)(2,3)(4,5)(6,7), tw_addr_2=4,5,6,7;
  - done asserts 19 cycles after the start edge; select=0 throughout.
- INTT ordering (N=8, mode=1):
  - stage 0 pairs (0,1)(2,3)(4,5)(6,7), tw_addr_2=4,5,6,7;
  - stage 1 pairs (0,2)(1,3)(4,6)(5,7), tw_addr_2=2,2,3,3;
  - stage 2 pairs (0,4)(1,5)(2,6)(3,7), tw_addr_2=1,1,1,1;
  - select=1 throughout.
- Write alignment: on every cycle, wr_en/wr_addr equal rd_en/rd_addr from 2 cycles earlier. Exactly 12 wr_en pulses occur per transform (N=8), and no wr_en occurs in the same cycle as the next stage's first rd_en.
- Ignored start: pulse start with mode=1 mid-run of an NTT -> the sequence and select are unchanged and done fires once. A start on the cycle after done begins a new transform.
- Abort: assert rst_n=0 during stage 1 -> next cycle all outputs are 0 and no done or wr_en occurs. A following start runs a full, correct transform from stage 0.
